// File: rtl/vec_shift_pkg.sv
// Shared types and defaults for the vector shift units.
package vec_shift_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } vshr_state_e;

  typedef enum logic [1:0] {
    SH_LOGIC = 2'd0,
    SH_ARITH = 2'd1,
    SH_ROT   = 2'd2
  } vshr_mode_e;

endpackage

// File: rtl/shr_lane_step.sv
// One-bit right step for a single lane; the mode selects the bit that enters the MSB.
module shr_lane_step
  import vec_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_data
);

  logic fill;

  always_comb begin
    fill = 1'b0;
    case (mode)
      SH_ARITH: fill = data[WIDTH-1];
      SH_ROT:   fill = data[0];
      default:  fill = 1'b0;
    endcase
    next_data = {fill, data[WIDTH-1:1]};
  end

endmodule

// File: rtl/vector_right_shift_unit.sv
// Iterative per-lane right shifter, one bit position per cycle, valid/ready on both sides.
// Define VSHR_ROTATE_EN to add the in_rot port and rotate-right mode.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// SHIFT | all lanes step right once per cycle while count runs down
// DONE  | out_valid high, result held until out_ready
module vector_right_shift_unit
  import vec_shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LANES   = DEF_LANES,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [SHAMT_W-1:0]     in_shamt,
  input  logic                   in_arith,
`ifdef VSHR_ROTATE_EN
  input  logic                   in_rot,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]             state;
  logic [SHAMT_W-1:0]     count;
  logic [1:0]             mode;
  logic [LANES*WIDTH-1:0] data_q;
  logic [LANES*WIDTH-1:0] step_data;

  logic [SHAMT_W-1:0]     count_sel;
  logic [1:0]             mode_sel;

  always_comb begin
    count_sel = '0;
    mode_sel  = SH_LOGIC;
`ifdef VSHR_ROTATE_EN
    if (in_rot) begin
      // A full-width rotate is the identity, so only the residue matters.
      count_sel = in_shamt % SHAMT_W'(WIDTH);
      mode_sel  = SH_ROT;
    end else begin
      count_sel = (in_shamt >= SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : in_shamt;
      mode_sel  = in_arith ? SH_ARITH : SH_LOGIC;
    end
`else
    count_sel = (in_shamt >= SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : in_shamt;
    mode_sel  = in_arith ? SH_ARITH : SH_LOGIC;
`endif
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    shr_lane_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .data     (data_q[i*WIDTH +: WIDTH]),
      .mode     (mode),
      .next_data(step_data[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      mode   <= SH_LOGIC;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            mode   <= mode_sel;
            count  <= count_sel;
            state  <= (count_sel == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_q <= step_data;
          count  <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          // Handoff cycle never accepts; in_ready only rises once back in IDLE.
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = data_q;

endmodule
